// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types for the round-robin arbiter
//
// Purpose: state encoding and counter width shared by rr_arbiter_n.
// Ports:   none (package).
// Config:  the hold counter width is only used when ARB_TIMEOUT_EN is defined.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Wide enough for any legal TIMEOUT (2..65535).
  localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/rr_arbiter_n_if.sv
// rtl/rr_arbiter_n_if.sv - request/grant bundle between requesters and the arbiter
//
// Purpose: groups the request/release inputs and the registered grant outputs.
// Signals:
//   req           m  request per requester (level)
//   done          1  current owner releases the grant
//   gnt           m  one-hot grant
//   gnt_id        n  binary index of the owner
//   gnt_vld       1  a grant is active
//   timeout_pulse 1  forced-release indication (ARB_TIMEOUT_EN builds only)
// Modports: master = requester side, slave = arbiter side.
interface rr_arbiter_n_if #(
  parameter int n = 3
) ();

  localparam int m = 1 << n;

  logic [m-1:0] req;
  logic         done;
  logic [m-1:0] gnt;
  logic [n-1:0] gnt_id;
  logic         gnt_vld;
  logic         timeout_pulse;

  modport master (
    output req, done,
    input  gnt, gnt_id, gnt_vld, timeout_pulse
  );

  modport slave (
    input  req, done,
    output gnt, gnt_id, gnt_vld, timeout_pulse
  );

endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating-priority pick
//
// Purpose: finds the first requester after index last_i, wrapping upward,
//          so that last_i itself has the lowest priority.
// Ports:
//   req_i   m  request vector
//   last_i  n  previous owner (lowest priority)
//   found_o 1  at least one request present
//   id_o    n  winning index (valid when found_o=1)
module rr_pick #(
  parameter int n = 3,
  localparam int m = 1 << n
) (
  input  logic [m-1:0] req_i,
  input  logic [n-1:0] last_i,
  output logic         found_o,
  output logic [n-1:0] id_o
);

  logic [n-1:0] shift;
  logic [n-1:0] idx;
  logic [m-1:0] rot;
  logic [n-1:0] pos;

  // n-bit arithmetic makes (last+1) mod m wrap for free.
  assign shift = last_i + 1'b1;

  // Rotate right by shift: rot[0] is the highest-priority requester.
  always_comb begin
    rot = '0;
    idx = '0;
    for (int i = 0; i < m; i++) begin
      idx    = i[n-1:0] + shift;
      rot[i] = req_i[idx];
    end
  end

  // Fixed lowest-index-first pick; scanning downward lets the lowest win.
  always_comb begin
    found_o = 1'b0;
    pos     = '0;
    for (int i = m - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found_o = 1'b1;
        pos     = i[n-1:0];
      end
    end
  end

  assign id_o = pos + shift;

endmodule

// File: rtl/rr_arbiter_n.sv
// rtl/rr_arbiter_n.sv - round-robin arbiter with hold-until-release grant
//
// Purpose: grants one shared resource to one of m = 2^n requesters, holds the
//          grant until the owner releases it, then rotates so the last owner
//          has the lowest priority. Optional forced release via ARB_TIMEOUT_EN.
// Ports:
//   clk  1  rising-edge clock
//   rst  1  synchronous active-high reset
//   bus     rr_arbiter_n_if.slave (req, done in; gnt, gnt_id, gnt_vld,
//           timeout_pulse out, all outputs registered)
// Parameters: n (index width), TIMEOUT (max hold cycles, ARB_TIMEOUT_EN only).
// Macro: ARB_TIMEOUT_EN enables the hold counter and timeout_pulse.
module rr_arbiter_n
  import arb_pkg::*;
#(
  parameter int n       = 3,
  parameter int TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rst,
  rr_arbiter_n_if.slave  bus
);

  localparam int m = 1 << n;

  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("rr_arbiter_n: TIMEOUT must be within 2..65535");
  end

  state_t       state_q, state_d;
  logic [n-1:0] last_q, last_d;
  logic [m-1:0] gnt_q, gnt_d;
  logic [n-1:0] gnt_id_q, gnt_id_d;
  logic         gnt_vld_q, gnt_vld_d;

  logic         vol_rel;
  logic         force_rel;
  logic         rel;
  logic [n-1:0] pick_last;
  logic         found;
  logic [n-1:0] win_id;

  assign vol_rel = bus.done | ~bus.req[gnt_id_q];

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tp_q, tp_d;

  assign force_rel = (cnt_q == CNT_W'(TIMEOUT - 1)) & ~vol_rel;
`else
  assign force_rel = 1'b0;
`endif

  assign rel = vol_rel | force_rel;

  // In GRANT the releasing owner becomes the new "last" on this same edge,
  // so the one picker serves both the idle path and the handover path.
  assign pick_last = (state_q == GRANT) ? gnt_id_q : last_q;

  rr_pick #(.n(n)) u_pick (
    .req_i   (bus.req),
    .last_i  (pick_last),
    .found_o (found),
    .id_o    (win_id)
  );

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    gnt_vld_d = gnt_vld_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    tp_d      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d   = GRANT;
          gnt_d     = {{(m-1){1'b0}}, 1'b1} << win_id;
          gnt_id_d  = win_id;
          gnt_vld_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end
      GRANT: begin
        if (rel) begin
          last_d = gnt_id_q;
`ifdef ARB_TIMEOUT_EN
          tp_d   = force_rel;
          cnt_d  = '0;
`endif
          if (found) begin
            gnt_d    = {{(m-1){1'b0}}, 1'b1} << win_id;
            gnt_id_d = win_id;
          end else begin
            state_d   = IDLE;
            gnt_d     = '0;
            gnt_vld_d = 1'b0;
          end
        end else begin
`ifdef ARB_TIMEOUT_EN
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= '1;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      gnt_vld_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= '0;
      tp_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      gnt_vld_q <= gnt_vld_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      tp_q      <= tp_d;
`endif
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_id  = gnt_id_q;
  assign bus.gnt_vld = gnt_vld_q;
`ifdef ARB_TIMEOUT_EN
  assign bus.timeout_pulse = tp_q;
`else
  assign bus.timeout_pulse = 1'b0;
`endif

endmodule
